// File: rtl/bcd_tick_counter.sv
// N-digit BCD up/down counter advanced by a programmable prescaler tick,
// driving a time-multiplexed 7-segment display with one-hot digit select.
module bcd_tick_counter #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_W    = 24,
  parameter int DEFAULT_COUNT = 10_000_000,
  parameter int SCAN_DIV      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              cfg_compare,
  input  logic                    up_down,
  input  logic                    hold,
  input  logic                    clear,
  output logic                    tick_out,
  output logic                    wrap_out,
  output logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int EXT_W  = (PRESCALE_W > 18) ? PRESCALE_W : 18;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // One BCD step with ripple carry/borrow; MSB of the result is the full-range wrap flag.
  function automatic logic [DW:0] bcd_step(input logic [DW-1:0] d, input logic up);
    logic [DW-1:0] r;
    logic          c;
    logic [3:0]    nib;
    r = d;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = d[4*i +: 4];
      if (c) begin
        if (up) begin
          if (nib == 4'd9) nib = 4'd0;
          else begin
            nib = nib + 4'd1;
            c   = 1'b0;
          end
        end else begin
          if (nib == 4'd0) nib = 4'd9;
          else begin
            nib = nib - 4'd1;
            c   = 1'b0;
          end
        end
      end
      r[4*i +: 4] = nib;
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [NUM_DIGITS-1:0] rotl(input logic [NUM_DIGITS-1:0] s);
    logic [NUM_DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) r[(i + 1) % NUM_DIGITS] = s[i];
    return r;
  endfunction

  logic [PRESCALE_W-1:0] presc;
  logic [PRESCALE_W-1:0] cmp_p0;
  logic [EXT_W-1:0]      cmp_ext;
  logic                  tick_p0;
  logic [DW:0]           step_p0;

  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      dig_idx;
  logic [IDX_W-1:0]      next_idx;
  logic [NUM_DIGITS-1:0] next_sel;
  logic                  scan_wrap;
  logic [3:0]            shown_digit;

  // Stage p0: compare selection, tick decision and next digit value
  always_comb begin
    cmp_ext = EXT_W'({cfg_compare, 10'b0});
    cmp_p0  = (cfg_compare == 8'd0) ? PRESCALE_W'(DEFAULT_COUNT) : cmp_ext[PRESCALE_W-1:0];
    tick_p0 = (presc >= cmp_p0);
    step_p0 = bcd_step(digits_bcd, up_down);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      digits_bcd <= '0;
      tick_out   <= 1'b0;
      wrap_out   <= 1'b0;
    end else if (clear) begin
      presc      <= '0;
      digits_bcd <= '0;
      tick_out   <= 1'b0;
      wrap_out   <= 1'b0;
    end else if (!ena || hold) begin
      tick_out <= 1'b0;
      wrap_out <= 1'b0;
    end else if (tick_p0) begin
      presc      <= '0;
      digits_bcd <= step_p0[DW-1:0];
      wrap_out   <= step_p0[DW];
      tick_out   <= 1'b1;
    end else begin
      presc    <= presc + PRESCALE_W'(1);
      tick_out <= 1'b0;
      wrap_out <= 1'b0;
    end
  end

  // Scan stage: segments are decoded for the digit that dig_sel selects after this edge
  always_comb begin
    scan_wrap   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    next_idx    = dig_idx;
    next_sel    = dig_sel;
    if (scan_wrap) begin
      next_sel = rotl(dig_sel);
      next_idx = (dig_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
    end
    shown_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == next_idx) shown_digit = digits_bcd[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      dig_sel  <= NUM_DIGITS'(1);
      seg_out  <= 7'h3F;
    end else if (!ena) begin
      seg_out <= 7'h00;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      dig_idx  <= next_idx;
      dig_sel  <= next_sel;
      seg_out  <= seg7(shown_digit);
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: 4 digits, DEFAULT_COUNT=4 (tick period 5), SCAN_DIV=2.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  cfg_compare;
  logic        up_down;
  logic        hold;
  logic        clear;
  logic        tick_out;
  logic        wrap_out;
  logic [15:0] digits_bcd;
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;

  int checks = 0;
  int errors = 0;
  logic [3:0] saved_sel;

  bcd_tick_counter #(
    .NUM_DIGITS(4),
    .PRESCALE_W(24),
    .DEFAULT_COUNT(4),
    .SCAN_DIV(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .cfg_compare(cfg_compare),
    .up_down(up_down),
    .hold(hold),
    .clear(clear),
    .tick_out(tick_out),
    .wrap_out(wrap_out),
    .digits_bcd(digits_bcd),
    .seg_out(seg_out),
    .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input logic [3:0] v, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (dig_sel === v) found = 1'b1;
      else step(1);
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_compare = 8'd0; up_down = 1'b1; hold = 1'b0; clear = 1'b0;
    step(2);
    check("rst_digits", digits_bcd, 32'h0000);
    check("rst_tick", tick_out, 0);
    check("rst_wrap", wrap_out, 0);
    check("rst_seg", seg_out, 32'h3F);
    check("rst_sel", dig_sel, 32'h1);

    // Tick every 5 cycles
    rst_n = 1'b1;
    step(4); check("t1_pre", tick_out, 0);
    step(1); check("t1_tick", tick_out, 1); check("t1_dig", digits_bcd, 32'h0001);
    step(1); check("t1_post", tick_out, 0);
    step(4); check("t2_tick", tick_out, 1); check("t2_dig", digits_bcd, 32'h0002);
    step(5); check("t3_tick", tick_out, 1); check("t3_dig", digits_bcd, 32'h0003);

    // Clear then down-wrap 0000 -> 9999
    clear = 1'b1;
    step(1); check("clr_dig", digits_bcd, 32'h0000); check("clr_tick", tick_out, 0);
    clear = 1'b0; up_down = 1'b0;
    step(4); check("dn_pre", tick_out, 0);
    step(1); check("dnw_dig", digits_bcd, 32'h9999); check("dnw_wrap", wrap_out, 1);
    check("dnw_tick", tick_out, 1);
    up_down = 1'b1;
    step(1); check("dnw_wrap_off", wrap_out, 0); check("dnw_tick_off", tick_out, 0);
    step(3); check("upw_pre", tick_out, 0);
    step(1); check("upw_dig", digits_bcd, 32'h0000); check("upw_wrap", wrap_out, 1);
    check("upw_tick", tick_out, 1);

    // Carry and borrow across a digit boundary
    step(45); check("c9_dig", digits_bcd, 32'h0009); check("c9_wrap", wrap_out, 0);
    step(5); check("c10_dig", digits_bcd, 32'h0010);
    up_down = 1'b0;
    step(5); check("b9_dig", digits_bcd, 32'h0009); check("b9_wrap", wrap_out, 0);

    // cfg_compare=1 -> compare 1024, period 1025
    up_down = 1'b1; cfg_compare = 8'd1;
    step(1024); check("c1k_pre", tick_out, 0); check("c1k_pre_dig", digits_bcd, 32'h0009);
    step(1); check("c1k_tick", tick_out, 1); check("c1k_dig", digits_bcd, 32'h0010);

    // Lowering compare below the prescaler ticks on the next edge
    step(80);
    cfg_compare = 8'd0;
    step(1); check("drop_tick", tick_out, 1); check("drop_dig", digits_bcd, 32'h0011);
    step(5); check("drop_next", tick_out, 1); check("drop_next_dig", digits_bcd, 32'h0012);

    // Hold freezes prescaler and digits; scan keeps rotating
    step(2);
    hold = 1'b1; saved_sel = dig_sel;
    step(20);
    check("hold_dig", digits_bcd, 32'h0012); check("hold_tick", tick_out, 0);
    check("hold_sel", dig_sel, {28'd0, saved_sel[1:0], saved_sel[3:2]});
    hold = 1'b0;
    step(2); check("hold_rel_pre", tick_out, 0);
    step(1); check("hold_rel_tick", tick_out, 1); check("hold_rel_dig", digits_bcd, 32'h0013);

    // Clear overrides hold
    hold = 1'b1; clear = 1'b1;
    step(1); check("clrh_dig", digits_bcd, 32'h0000); check("clrh_tick", tick_out, 0);
    hold = 1'b0; clear = 1'b0;

    // Count to 1234 and check the display scan
    step(5 * 1234); check("d1234", digits_bcd, 32'h1234); check("d1234_tick", tick_out, 1);
    hold = 1'b1;
    wait_sel(4'b0001, "scan_sync0");
    wait_sel(4'b0010, "scan_sync1");
    check("scan_s1a", seg_out, 32'h4F);
    step(1); check("scan_sel1b", dig_sel, 32'h2); check("scan_s1b", seg_out, 32'h4F);
    step(1); check("scan_sel2", dig_sel, 32'h4); check("scan_s2", seg_out, 32'h5B);
    step(2); check("scan_sel3", dig_sel, 32'h8); check("scan_s3", seg_out, 32'h06);
    step(2); check("scan_sel0", dig_sel, 32'h1); check("scan_s0", seg_out, 32'h66);
    step(2); check("scan_sel1r", dig_sel, 32'h2); check("scan_s1r", seg_out, 32'h4F);

    // ena low blanks segments and freezes everything
    hold = 1'b0; ena = 1'b0; saved_sel = dig_sel;
    step(1); check("ena_seg", seg_out, 32'h00);
    step(7);
    check("ena_sel", dig_sel, {28'd0, saved_sel}); check("ena_dig", digits_bcd, 32'h1234);
    check("ena_tick", tick_out, 0); check("ena_seg2", seg_out, 32'h00);
    ena = 1'b1;
    step(1); check("ena_back_nz", {31'd0, seg_out != 7'h00}, 32'd1);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    check("arst_dig", digits_bcd, 32'h0000);
    check("arst_seg", seg_out, 32'h3F);
    check("arst_sel", dig_sel, 32'h1);
    check("arst_tick", tick_out, 0);
    check("arst_wrap", wrap_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
